instr_seq: RTL and testbench
============================

Name: instr_seq

Overview:
- Synthesisable, parametrised instruction sequencer that drives the `ir` input of `Proc` from a loadable program table.
- Each entry holds an instruction word plus a hold count. The hold count is the number of un-stalled cycles that entry is presented.
- Supports stall back-pressure, optional looping and a completion pulse.
- Replaces hard-coded, delay-timed instruction sequences in processor benches and FPGA bring-up builds with a reusable block.

Parameters:
- XLEN, 32, instruction width in bits.
- DEPTH, 16, number of program entries; must be a power of 2, ≥ 2.
- HOLD_W, 8, width of the per-entry hold count.
- AW, $clog2(DEPTH), entry index width (derived; not overridden).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- load_en  in  1  write one table entry this cycle.
- load_addr  in  AW  entry index to write.
- load_instr  in  XLEN  instruction word to store.
- load_hold  in  HOLD_W  hold cycles for the entry; 0 is treated as 1.
- prog_len  in  AW+1  number of valid entries (0..DEPTH); sampled on start.
- start  in  1  begin execution at entry 0.
- loop_en  in  1  wrap to entry 0 after the last entry; sampled continuously.
- stall  in  1  freeze sequencing; ir is held.
- ir  out  XLEN  instruction presented to the processor.
- ir_valid  out  1  ir is a program entry, not filler.
- idx  out  AW  index of the entry currently presented.
- busy  out  1  state is RUN.
- done  out  1  one-cycle pulse when the program completes.

Behaviour:
- Reset values: ir = NOP_INSTR (32'h00000013, addi x0,x0,0), ir_valid=0, idx=0, busy=0, done=0, state=IDLE, hold counter=0.
- Table contents are not reset.
- States are IDLE, RUN and DONE, all registered.
- IDLE:
  - load_en writes {load_instr, load_hold} to entry load_addr at the clock edge.
  - start with prog_len ≥ 1: latch len = min(prog_len, DEPTH); next cycle state=RUN, ir=entry[0].instr, ir_valid=1, idx=0, counter=0. Latency from start is 1 cycle.
  - start with prog_len = 0: next cycle state=DONE, done=1, ir stays NOP.
  - start and load_en in the same cycle: the write happens first, and entry 0 is presented from the new contents when load_addr=0 (write-through).
- RUN:
  - load_en is ignored; start is ignored.
  - stall=1: counter, idx and ir are frozen.
  - stall=0: counter increments. When counter == max(hold,1)-1, the entry is retired.
  - Retiring entry idx < len-1: next cycle idx+1, ir=entry[idx+1], counter=0.
  - Retiring the last entry with loop_en=1: next cycle idx=0, ir=entry[0], counter=0, no done pulse.
  - Retiring the last entry with loop_en=0: next cycle state=DONE, ir=NOP, ir_valid=0.
  - Each entry is therefore visible for exactly max(hold,1) un-stalled cycles.
- DONE: done=1 for exactly this one cycle, busy=0, then IDLE. A start in DONE is ignored.
- Counter width is HOLD_W; it never wraps, because comparison happens before increment.
- Reset mid-RUN: the next cycle is identical to post-reset. No done pulse; ir=NOP.
- stall in IDLE or DONE has no effect.

Decomposition:
- Shared package `seq_pkg`:
  - NOP_INSTR constant.
  - State encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - RISC-V opcode constants (OP_IMM=7'b0010011, LOAD=7'b0000011, STORE=7'b0100011) for benches.
- One sub-module, `seq_table`:
  - DEPTH × (XLEN+HOLD_W) register array.
  - Synchronous write, asynchronous read.
  - Write-through when write and read addresses match.
- The FSM, counter and output registers live in `instr_seq`.

Test Plan:
- Basic sequence:
  - Stimulus: load entry0={0x00500093,5}, entry1={0x00102223,10}, entry2={0x00402103,10}; prog_len=3; pulse start, stall=0.
  - Response: ir=0x00500093 for cycles 1-5, 0x00102223 for cycles 6-15, 0x00402103 for cycles 16-25; done=1 at cycle 26 only; ir=0x00000013 afterwards.
- Stall:
  - Stimulus: same program; stall=1 for 4 cycles starting at cycle 3.
  - Response: entry0 is visible for 9 cycles and idx is frozen; done arrives at cycle 30.
- Hold 0 and loop:
  - Stimulus: entry0 hold=0, entry1 hold=2; prog_len=2; loop_en=1.
  - Response: ir alternates in the pattern e0, e1, e1, e0 …; done is never asserted. Dropping loop_en ends the program after the current e1 and gives a done pulse.
- Zero length:
  - Stimulus: prog_len=0, start.
  - Response: done=1 on the next cycle, ir_valid stays 0, busy stays 0.
- Reset and ignored inputs:
  - Stimulus: reset asserted at cycle 7 of the basic sequence; load_en asserted during RUN.
  - Response: next cycle ir=0x00000013, busy=0, idx=0, no done pulse. A rerun shows the table unchanged by the load attempted during RUN.
- Parametrisation:
  - Stimulus: DEPTH=4, prog_len=4.
  - Response: all 4 entries are presented; prog_len values above DEPTH are clamped to 4.

Source files
------------

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared constants and state encoding for the instruction sequencer
package seq_pkg;

  // addi x0, x0, 0: presented whenever no program entry is active
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  // RISC-V major opcodes, handy when composing programs
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;

endpackage

// File: rtl/seq_table.sv
// rtl/seq_table.sv - program table: DEPTH entries of {instr, hold}
// Ports:
//   clk             clock
//   we/waddr        write strobe and entry index
//   winstr/whold    data written at the rising edge
//   raddr           combinational read index
//   rinstr/rhold    read data; forwards the write data when waddr == raddr
module seq_table #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 16,
  parameter int HOLD_W = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [XLEN-1:0]   winstr,
  input  logic [HOLD_W-1:0] whold,
  input  logic [AW-1:0]     raddr,
  output logic [XLEN-1:0]   rinstr,
  output logic [HOLD_W-1:0] rhold
);

  logic [XLEN-1:0]   instr_mem [DEPTH];
  logic [HOLD_W-1:0] hold_mem  [DEPTH];
  logic              bypass;

  // Contents are deliberately not reset; a program survives sequencer resets.
  always_ff @(posedge clk) begin
    if (we) begin
      instr_mem[waddr] <= winstr;
      hold_mem[waddr]  <= whold;
    end
  end

  // Write-through so an entry written in the same cycle as start is seen.
  assign bypass = we && (waddr == raddr);
  assign rinstr = bypass ? winstr : instr_mem[raddr];
  assign rhold  = bypass ? whold  : hold_mem[raddr];

endmodule

// File: rtl/instr_seq.sv
// rtl/instr_seq.sv - table-driven instruction sequencer feeding a processor ir input
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   load_en/addr/...   write one table entry (accepted only while idle)
//   prog_len           number of valid entries, sampled on start, clamped to DEPTH
//   start              begin execution at entry 0
//   loop_en            wrap to entry 0 after the last entry
//   stall              freeze sequencing and hold ir
//   ir, ir_valid, idx  presented instruction, validity and entry index
//   busy, done         running flag and one-cycle completion pulse
module instr_seq
  import seq_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 16,
  parameter int HOLD_W = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [AW-1:0]     load_addr,
  input  logic [XLEN-1:0]   load_instr,
  input  logic [HOLD_W-1:0] load_hold,
  input  logic [AW:0]       prog_len,
  input  logic              start,
  input  logic              loop_en,
  input  logic              stall,
  output logic [XLEN-1:0]   ir,
  output logic              ir_valid,
  output logic [AW-1:0]     idx,
  output logic              busy,
  output logic              done
);

  localparam logic [AW:0]     DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [XLEN-1:0] NOP_X   = XLEN'(NOP_INSTR);

  seq_state_t        state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [HOLD_W-1:0] last_q, last_d;
  logic [AW:0]       len_q, len_d;
  logic [XLEN-1:0]   ir_q, ir_d;
  logic              irv_q, irv_d;

  logic [AW-1:0]     rd_addr;
  logic [XLEN-1:0]   rd_instr;
  logic [HOLD_W-1:0] rd_hold;
  logic              present;
  logic              tbl_we;
  logic [AW:0]       idx_inc;

  assign tbl_we  = load_en && (state_q == ST_IDLE);
  assign idx_inc = {1'b0, idx_q} + 1'b1;

  seq_table #(
    .XLEN   (XLEN),
    .DEPTH  (DEPTH),
    .HOLD_W (HOLD_W),
    .AW     (AW)
  ) u_table (
    .clk    (clk),
    .we     (tbl_we),
    .waddr  (load_addr),
    .winstr (load_instr),
    .whold  (load_hold),
    .raddr  (rd_addr),
    .rinstr (rd_instr),
    .rhold  (rd_hold)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    len_d   = len_q;
    ir_d    = ir_q;
    irv_d   = irv_q;
    rd_addr = '0;
    present = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (prog_len == '0) begin
            state_d = ST_DONE;
          end else begin
            len_d   = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
            state_d = ST_RUN;
            present = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (!stall) begin
          // Compare before incrementing so the counter never wraps.
          if (cnt_q == last_q) begin
            if (idx_inc < len_q) begin
              present = 1'b1;
              rd_addr = idx_inc[AW-1:0];
            end else if (loop_en) begin
              present = 1'b1;
            end else begin
              state_d = ST_DONE;
              ir_d    = NOP_X;
              irv_d   = 1'b0;
              idx_d   = '0;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Load the entry at rd_addr into the output registers. The retire
    // compare value is precomputed so a hold of 0 behaves as 1.
    if (present) begin
      ir_d   = rd_instr;
      irv_d  = 1'b1;
      idx_d  = rd_addr;
      cnt_d  = '0;
      last_d = (rd_hold == '0) ? '0 : rd_hold - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      len_q   <= '0;
      ir_q    <= NOP_X;
      irv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      len_q   <= len_d;
      ir_q    <= ir_d;
      irv_q   <= irv_d;
    end
  end

  assign ir       = ir_q;
  assign ir_valid = irv_q;
  assign idx      = idx_q;
  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_instr_seq.sv
// tb/tb_instr_seq.sv - directed self-checking bench for instr_seq
module tb_instr_seq;
  import seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;

  // default-parameter instance
  logic        load_en;
  logic [3:0]  load_addr;
  logic [31:0] load_instr;
  logic [7:0]  load_hold;
  logic [4:0]  prog_len;
  logic        start, loop_en, stall;
  logic [31:0] ir;
  logic        ir_valid;
  logic [3:0]  idx;
  logic        busy, done;

  // DEPTH=4 instance
  logic        p_load_en;
  logic [1:0]  p_load_addr;
  logic [31:0] p_load_instr;
  logic [7:0]  p_load_hold;
  logic [2:0]  p_prog_len;
  logic        p_start, p_loop_en, p_stall;
  logic [31:0] p_ir;
  logic        p_ir_valid;
  logic [1:0]  p_idx;
  logic        p_busy, p_done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic [31:0] E0 = 32'h0050_0093;
  localparam logic [31:0] E1 = 32'h0010_2223;
  localparam logic [31:0] E2 = 32'h0040_2103;

  always #5 clk = ~clk;

  instr_seq dut (
    .clk(clk), .reset(reset),
    .load_en(load_en), .load_addr(load_addr), .load_instr(load_instr), .load_hold(load_hold),
    .prog_len(prog_len), .start(start), .loop_en(loop_en), .stall(stall),
    .ir(ir), .ir_valid(ir_valid), .idx(idx), .busy(busy), .done(done)
  );

  instr_seq #(.DEPTH(4)) dut4 (
    .clk(clk), .reset(reset),
    .load_en(p_load_en), .load_addr(p_load_addr), .load_instr(p_load_instr), .load_hold(p_load_hold),
    .prog_len(p_prog_len), .start(p_start), .loop_en(p_loop_en), .stall(p_stall),
    .ir(p_ir), .ir_valid(p_ir_valid), .idx(p_idx), .busy(p_busy), .done(p_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      pass_cnt++;
  endtask

  // inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [31:0] ins, input logic [7:0] h);
    load_en = 1'b1; load_addr = a; load_instr = ins; load_hold = h;
    tick();
    load_en = 1'b0;
  endtask

  // Three-entry program {E0,5},{E1,10},{E2,10}; an optional stall window
  // inside entry 0 stretches every later boundary by its length.
  task automatic run_prog3(input int st_from, input int st_n, input string nm);
    int b0, b1, b2;
    logic [31:0] e;
    logic [3:0]  ei;
    b0 = 5 + st_n; b1 = 15 + st_n; b2 = 25 + st_n;
    prog_len = 5'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= b2 + 3; c++) begin
      if (c <= b0)      begin e = E0; ei = 4'd0; end
      else if (c <= b1) begin e = E1; ei = 4'd1; end
      else if (c <= b2) begin e = E2; ei = 4'd2; end
      else              begin e = NOP_INSTR; ei = 4'd0; end
      check($sformatf("%s ir c%0d", nm, c), 64'(ir), 64'(e));
      check($sformatf("%s idx c%0d", nm, c), 64'(idx), 64'(ei));
      check($sformatf("%s done c%0d", nm, c), 64'(done), 64'(c == b2 + 1));
      check($sformatf("%s busy c%0d", nm, c), 64'(busy), 64'(c <= b2));
      if (c == b2 + 2)
        check($sformatf("%s valid c%0d", nm, c), 64'(ir_valid), 64'd0);
      if (c == 1)      check({nm, " op_imm"}, 64'(ir[6:0]), 64'(OP_IMM));
      if (c == b0 + 1) check({nm, " op_store"}, 64'(ir[6:0]), 64'(STORE));
      if (c == b1 + 1) check({nm, " op_load"}, 64'(ir[6:0]), 64'(LOAD));
      stall = (c >= st_from) && (c < st_from + st_n);
      start = (c == b2 + 1);   // start during DONE must be ignored
      tick();
    end
    start = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    load_en = 0; load_addr = 0; load_instr = 0; load_hold = 0;
    prog_len = 0; start = 0; loop_en = 0; stall = 0;
    p_load_en = 0; p_load_addr = 0; p_load_instr = 0; p_load_hold = 0;
    p_prog_len = 0; p_start = 0; p_loop_en = 0; p_stall = 0;
    tick(); tick();
    reset = 1'b0;

    check("rst ir", 64'(ir), 64'(NOP_INSTR));
    check("rst valid", 64'(ir_valid), 64'd0);
    check("rst idx", 64'(idx), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);

    load(4'd0, E0, 8'd5);
    load(4'd1, E1, 8'd10);
    load(4'd2, E2, 8'd10);

    run_prog3(0, 0, "basic");
    run_prog3(3, 4, "stall");

    // reset at cycle 7, with a load attempt during RUN at cycle 3
    prog_len = 5'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      check($sformatf("rr ir c%0d", c), 64'(ir), 64'(c <= 5 ? E0 : E1));
      load_en = (c == 3); load_addr = 4'd1; load_instr = 32'hdead_beef; load_hold = 8'd1;
      reset = (c == 7);
      tick();
    end
    load_en = 1'b0; reset = 1'b0;
    check("rr ir", 64'(ir), 64'(NOP_INSTR));
    check("rr valid", 64'(ir_valid), 64'd0);
    check("rr busy", 64'(busy), 64'd0);
    check("rr idx", 64'(idx), 64'd0);
    check("rr done", 64'(done), 64'd0);
    tick();
    check("rr done2", 64'(done), 64'd0);
    run_prog3(0, 0, "rerun");

    // hold 0 and loop: e0, e1, e1 repeating; loop_en dropped in cycle 10
    load(4'd0, 32'h0010_0093, 8'd0);
    load(4'd1, 32'h0020_0113, 8'd2);
    prog_len = 5'd2; loop_en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      logic [31:0] e;
      logic        first;
      first = ((c - 1) % 3) == 0;
      e = (c > 12) ? NOP_INSTR : (first ? 32'h0010_0093 : 32'h0020_0113);
      check($sformatf("loop ir c%0d", c), 64'(ir), 64'(e));
      check($sformatf("loop done c%0d", c), 64'(done), 64'(c == 13));
      if (c <= 12)
        check($sformatf("loop idx c%0d", c), 64'(idx), 64'(first ? 0 : 1));
      loop_en = (c < 10);
      tick();
    end
    loop_en = 1'b0;

    // zero length
    prog_len = 5'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("zero done", 64'(done), 64'd1);
    check("zero valid", 64'(ir_valid), 64'd0);
    check("zero busy", 64'(busy), 64'd0);
    check("zero ir", 64'(ir), 64'(NOP_INSTR));
    tick();
    check("zero done2", 64'(done), 64'd0);
    check("zero busy2", 64'(busy), 64'd0);

    // write-through: load entry 0 and start in the same cycle
    load_en = 1'b1; load_addr = 4'd0; load_instr = 32'h0030_0193; load_hold = 8'd3;
    prog_len = 5'd1; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("wt ir c%0d", c), 64'(ir), 64'(c <= 3 ? 32'h0030_0193 : NOP_INSTR));
      check($sformatf("wt done c%0d", c), 64'(done), 64'(c == 4));
      tick();
    end

    // DEPTH=4 instance, prog_len above DEPTH is clamped
    for (int i = 0; i < 4; i++) begin
      p_load_en = 1'b1; p_load_addr = 2'(i); p_load_instr = 32'h1000_0000 + 32'(i); p_load_hold = 8'd1;
      tick();
    end
    p_load_en = 1'b0;
    p_prog_len = 3'd7; p_start = 1'b1;
    tick();
    p_start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("p4 ir c%0d", c), 64'(p_ir), 64'(c <= 4 ? 32'h1000_0000 + 32'(c - 1) : NOP_INSTR));
      if (c <= 4) check($sformatf("p4 idx c%0d", c), 64'(p_idx), 64'(c - 1));
      check($sformatf("p4 done c%0d", c), 64'(p_done), 64'(c == 5));
      check($sformatf("p4 valid c%0d", c), 64'(p_ir_valid), 64'(c <= 4));
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
